scan_decoder: RTL and testbench

//   Parametrised SEL_W-to-2**SEL_W one-hot decoder with registered outputs and two modes.

---
 rtl/dec_pkg.sv | 22 ++
 rtl/next_idx_finder.sv | 28 ++
 rtl/scan_decoder.sv | 124 ++++++++++++
 tb/tb_scan_decoder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared encodings and helpers for scan_decoder: FSM state codes, one-hot decode, lowest-set-bit.
package dec_pkg;
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 256;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SHOW   = 2'd2;
  localparam logic [1:0] ST_BLANK  = 2'd3;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    return {{(MAX_OUT_W-1){1'b0}}, 1'b1} << sel;
  endfunction

  function automatic logic [MAX_SEL_W-1:0] first_set(input logic [MAX_OUT_W-1:0] mask);
    logic [MAX_SEL_W-1:0] r;
    r = '0;
    for (int k = MAX_OUT_W-1; k >= 0; k--)
      if (mask[k]) r = MAX_SEL_W'(k);
    return r;
  endfunction
endpackage

// File: rtl/next_idx_finder.sv
// Next set bit of mask strictly above idx, wrapping to the lowest set bit; 'none' when mask is empty.
module next_idx_finder
  import dec_pkg::*;
#(
  parameter int SEL_W = 2,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic [OUT_W-1:0] mask,
  input  logic [SEL_W-1:0] idx,
  output logic [SEL_W-1:0] nxt,
  output logic             none
);
  logic             hit;
  logic [SEL_W-1:0] above;

  always_comb begin
    hit   = 1'b0;
    above = '0;
    // descending scan leaves the lowest qualifying bit in 'above'
    for (int k = OUT_W-1; k >= 0; k--)
      if (mask[k] && (k > int'(idx))) begin
        hit   = 1'b1;
        above = SEL_W'(k);
      end
    none = ~|mask;
    nxt  = hit ? above : SEL_W'(first_set(MAX_OUT_W'(mask)));
  end
endmodule

// File: rtl/scan_decoder.sv
// One-hot decoder with DIRECT and prescaled SCAN modes plus inter-channel blanking.
// Define DEC_ACTIVE_LOW_EN to drive Y active-low (reset value all ones).
module scan_decoder
  import dec_pkg::*;
#(
  parameter int SEL_W     = 2,
  parameter int PRESCALE  = 100000,
  parameter int BLANK_CYC = 0,
  localparam int OUT_W    = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [OUT_W-1:0] scan_mask,
  output logic [OUT_W-1:0] Y,
  output logic [SEL_W-1:0] idx,
  output logic             tick
);
  localparam int CNT_W   = (PRESCALE > 1)  ? $clog2(PRESCALE)  : 1;
  localparam int BLK_W   = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int PS_LAST = PRESCALE - 1;
  localparam int BL_LAST = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] Y_RST = '1;
`else
  localparam logic [OUT_W-1:0] Y_RST = '0;
`endif

  function automatic logic [OUT_W-1:0] oh(input logic [SEL_W-1:0] s);
    logic [MAX_OUT_W-1:0] w;
    w = onehot(MAX_SEL_W'(s));
    return w[OUT_W-1:0];
  endfunction

  logic [1:0]       state, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [BLK_W-1:0] bcnt, bcnt_n;
  logic [SEL_W-1:0] idx_n, seed, nxt;
  logic [OUT_W-1:0] y_n;
  logic             tick_n, none, load, adv, entering;

  // seeding with the top index makes the wrap land on the lowest set bit
  assign entering = (state == ST_IDLE) || (state == ST_DIRECT);
  assign seed     = entering ? '1 : idx;

  next_idx_finder #(.SEL_W(SEL_W)) u_find (
    .mask (scan_mask),
    .idx  (seed),
    .nxt  (nxt),
    .none (none)
  );

  always_comb begin
    st_n   = state;
    idx_n  = idx;
    cnt_n  = cnt;
    bcnt_n = bcnt;
    y_n    = '0;
    tick_n = 1'b0;
    load   = 1'b0;
    adv    = 1'b0;
    if (!en) begin
      st_n = ST_IDLE;
    end else if (!mode) begin
      st_n  = ST_DIRECT;
      idx_n = sel;
      y_n   = oh(sel);
    end else if (none) begin
      st_n = ST_IDLE;
    end else begin
      case (state)
        ST_SHOW: begin
          if (cnt == CNT_W'(PS_LAST)) begin
            if (BLANK_CYC > 0) begin
              st_n   = ST_BLANK;
              bcnt_n = '0;
            end else begin
              adv = 1'b1;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
            y_n   = oh(idx) & scan_mask;
          end
        end
        ST_BLANK: begin
          if (bcnt == BLK_W'(BL_LAST)) adv = 1'b1;
          else bcnt_n = bcnt + BLK_W'(1);
        end
        default: load = 1'b1;
      endcase
      if (load || adv) begin
        st_n   = ST_SHOW;
        idx_n  = nxt;
        cnt_n  = '0;
        y_n    = oh(nxt) & scan_mask;
        tick_n = adv;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      bcnt  <= '0;
      idx   <= '0;
      tick  <= 1'b0;
      Y     <= Y_RST;
    end else begin
      state <= st_n;
      cnt   <= cnt_n;
      bcnt  <= bcnt_n;
      idx   <= idx_n;
      tick  <= tick_n;
`ifdef DEC_ACTIVE_LOW_EN
      Y     <= ~y_n;
`else
      Y     <= y_n;
`endif
    end
  end
endmodule

// File: tb/tb_scan_decoder.sv
// Directed scoreboard bench: DUT A (PRESCALE=4, BLANK_CYC=1), DUT B (PRESCALE=1, BLANK_CYC=0).
module tb_scan_decoder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, mode, en6, mode6;
  logic [1:0] sel, sel6, idx_a, idx_b;
  logic [3:0] mask, mask6, y_a, y_b;
  logic       tick_a, tick_b;

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(2), .PRESCALE(4), .BLANK_CYC(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .scan_mask(mask),
    .Y(y_a), .idx(idx_a), .tick(tick_a));

  scan_decoder #(.SEL_W(2), .PRESCALE(1), .BLANK_CYC(0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en6), .mode(mode6), .sel(sel6), .scan_mask(mask6),
    .Y(y_b), .idx(idx_b), .tick(tick_b));

  typedef struct packed {
    logic [3:0] y;
    logic [1:0] idx;
    logic       tick;
    logic       d6;
  } exp_t;

  exp_t  sb[$];
  string tq[$];
  int    errs = 0;
  int    checks = 0;

  function automatic logic [3:0] pol(input logic [3:0] v);
`ifdef DEC_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic push(input string tag, input logic [3:0] y, input logic [1:0] i,
                      input logic t, input logic d6);
    exp_t e;
    e.y = pol(y); e.idx = i; e.tick = t; e.d6 = d6;
    sb.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic check();
    exp_t       e;
    string      tag;
    logic [3:0] oy;
    logic [1:0] oi;
    logic       ot;
    e   = sb.pop_front();
    tag = tq.pop_front();
    oy  = e.d6 ? y_b : y_a;
    oi  = e.d6 ? idx_b : idx_a;
    ot  = e.d6 ? tick_b : tick_a;
    checks += 3;
    assert (oy === e.y) else begin
      errs++; $error("FAIL %s Y: got %b expected %b", tag, oy, e.y);
    end
    assert (oi === e.idx) else begin
      errs++; $error("FAIL %s idx: got %0d expected %0d", tag, oi, e.idx);
    end
    assert (ot === e.tick) else begin
      errs++; $error("FAIL %s tick: got %b expected %b", tag, ot, e.tick);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] y, input logic [1:0] i, input logic t);
    push(tag, y, i, t, 1'b0);
    @(posedge clk); #1;
    check();
  endtask

  task automatic step6(input string tag, input logic [3:0] y, input logic [1:0] i, input logic t);
    push(tag, y, i, t, 1'b1);
    @(posedge clk); #1;
    check();
  endtask

  // one full channel slot: 4 show cycles (tick on the first if advanced into) then 1 blank
  task automatic scan_ch(input string tag, input logic [1:0] ch, input logic ft);
    logic [3:0] v;
    v = 4'b0001 << ch;
    step(tag, v, ch, ft);
    repeat (3) step(tag, v, ch, 1'b0);
    step({tag, "_blank"}, 4'b0000, ch, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 0; mode = 0; sel = 0; mask = 0;
    en6 = 0; mode6 = 0; sel6 = 0; mask6 = 0;
    #2;
    push("reset_a", 4'b0000, 2'd0, 1'b0, 1'b0); check();
    push("reset_b", 4'b0000, 2'd0, 1'b0, 1'b1); check();
    @(posedge clk); #1;
    rst_n = 1'b1;

    en = 1; sel = 2'd2;
    step("direct_sel2", 4'b0100, 2'd2, 1'b0);
    sel = 2'd3;
    step("direct_sel3", 4'b1000, 2'd3, 1'b0);
    en = 0;
    step("en_off", 4'b0000, 2'd3, 1'b0);

    en = 1; mode = 1; mask = 4'b1111;
    scan_ch("scan_ch0", 2'd0, 1'b0);
    scan_ch("scan_ch1", 2'd1, 1'b1);
    scan_ch("scan_ch2", 2'd2, 1'b1);
    scan_ch("scan_ch3", 2'd3, 1'b1);
    step("scan_wrap", 4'b0001, 2'd0, 1'b1);
    en = 0;
    step("en_drop_show", 4'b0000, 2'd0, 1'b0);

    en = 1; mask = 4'b1010;
    scan_ch("m1010_ch1", 2'd1, 1'b0);
    scan_ch("m1010_ch3", 2'd3, 1'b1);
    step("m1010_wrap", 4'b0010, 2'd1, 1'b1);

    mask = 4'b0100;
    repeat (4) step("mask_clear_cur", 4'b0000, 2'd1, 1'b0);
    scan_ch("m0100_a", 2'd2, 1'b1);
    scan_ch("m0100_b", 2'd2, 1'b1);
    step("m0100_reselect", 4'b0100, 2'd2, 1'b1);

    mask = 4'b0000;
    repeat (2) step("mask_zero", 4'b0000, 2'd2, 1'b0);

    mask = 4'b1010;
    scan_ch("pre_rst", 2'd1, 1'b0);
    #3 rst_n = 1'b0;
    #1 push("rst_mid_blank", 4'b0000, 2'd0, 1'b0, 1'b0);
    check();
    @(posedge clk); #1;
    rst_n = 1'b1; mask = 4'b1111;
    step("restart_ch0", 4'b0001, 2'd0, 1'b0);
    step("restart_hold", 4'b0001, 2'd0, 1'b0);
    mode = 0; sel = 2'd3;
    step("mode_to_direct", 4'b1000, 2'd3, 1'b0);
    mode = 1;
    step("scan_reentry", 4'b0001, 2'd0, 1'b0);
    en = 0;

    en6 = 1; mode6 = 0; sel6 = 2'd0;
    step6("b_direct_sel0", 4'b0001, 2'd0, 1'b0);
    mode6 = 1; mask6 = 4'b1111;
    step6("b_entry", 4'b0001, 2'd0, 1'b0);
    step6("b_rot1", 4'b0010, 2'd1, 1'b1);
    step6("b_rot2", 4'b0100, 2'd2, 1'b1);
    step6("b_rot3", 4'b1000, 2'd3, 1'b1);
    step6("b_wrap", 4'b0001, 2'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
